axi4l_responder: RTL and testbench
==================================

Name: axi4l_responder

Overview:
AXI4-Lite slave that terminates the host configuration port. It converts AW/W/B and AR/R channel handshakes into single-cycle register-bus strobes toward the CORTEZ regpool (weights, biases, input grid, CORE_CTRL). It sits directly behind the network top-level AXI4-Lite port. At most one write and one read are outstanding at any time, and the two directions run independently.

Parameters:
ADDR_WIDTH, 32, AXI address width in bits
DATA_WIDTH, 32, AXI and register data width in bits
REG_IDX_WIDTH, 10, register word-index width; the decoded window is 4*2**REG_IDX_WIDTH bytes starting at 0

Ports:
CLK  in  1  clock
RSTN  in  1  reset, asynchronous assert, active-low
AWADDR  in  ADDR_WIDTH  write address
AWVALID / AWREADY  in / out  1  write-address handshake
WDATA  in  DATA_WIDTH  write data
WSTRB  in  DATA_WIDTH/8  byte enables
WVALID / WREADY  in / out  1  write-data handshake
BRESP  out  2  write response: 00 OKAY, 10 SLVERR
BVALID / BREADY  out / in  1  write-response handshake
ARADDR  in  ADDR_WIDTH  read address
ARVALID / ARREADY  in / out  1  read-address handshake
RDATA  out  DATA_WIDTH  read data
RRESP  out  2  read response
RVALID / RREADY  out / in  1  read-data handshake
REG_WEN  out  1  one-cycle register write strobe
REG_WIDX  out  REG_IDX_WIDTH  write word index
REG_WDATA  out  DATA_WIDTH  write data
REG_WSTRB  out  DATA_WIDTH/8  byte enables
REG_REN  out  1  one-cycle register read strobe
REG_RIDX  out  REG_IDX_WIDTH  read word index
REG_RDATA  in  DATA_WIDTH  regpool data; valid exactly one cycle after REG_REN

Behaviour:
- Reset values: all READY, VALID, WEN and REN outputs are 0. All data, index and response outputs are 0. The write FSM is W_IDLE and the read FSM is R_IDLE. After RSTN deasserts, AWREADY, WREADY and ARREADY rise on the first CLK edge.
- Address decode: word index = ADDR[REG_IDX_WIDTH+1:2]. The address is in range only when ADDR[1:0]==0 and ADDR[ADDR_WIDTH-1:REG_IDX_WIDTH+2]==0.
- Write FSM states:
  - W_IDLE: AWREADY=WREADY=1. If AW and W handshake in the same cycle, go to W_ISSUE. AW alone goes to W_WAIT_W with AWREADY=0. W alone goes to W_WAIT_AW with WREADY=0.
  - W_WAIT_W / W_WAIT_AW: capture the missing beat, then go to W_ISSUE.
  - W_ISSUE (one cycle): REG_WEN=1 if in range, else 0. BVALID=1 with BRESP registered. Next state is W_RESP.
  - W_RESP: hold BVALID/BRESP until BREADY. Return to W_IDLE on the BVALID&&BREADY edge. If BREADY is already high in W_ISSUE, return to W_IDLE directly.
  - Latency: AW+W handshake at edge t gives REG_WEN and BVALID high in cycle t+1.
  - AWREADY and WREADY are 0 from capture until the B handshake completes.
- Read FSM states:
  - R_IDLE: ARREADY=1. A handshake at edge t moves to R_ISSUE.
  - R_ISSUE: REG_REN=1 (in range only), ARREADY=0.
  - R_DATA: RDATA = REG_RDATA if in range, else 0. RVALID=1 in cycle t+2. RDATA/RRESP are held until RREADY, then return to R_IDLE.
- Simultaneous write and read run concurrently. If both target the same index in the same cycle, REG_RDATA returns the pre-write value; this is the regpool's responsibility and is documented here for the bench.
- VALID never depends combinationally on READY. Outputs held during a stalled response must not change.
- A mid-transaction RSTN assertion immediately clears BVALID, RVALID and the strobes, and abandons the transaction. No REG_WEN is issued for a half-captured AW/W.

Optional Feature:
AXI4L_SLVERR_EN
- Defined: out-of-range or misaligned accesses return SLVERR (10). The write is dropped and RDATA=0.
- Undefined: the same accesses return OKAY (00), still with the write dropped and RDATA=0.
- In-range behaviour is identical in both builds.

Decomposition:
- Shared package axi4l_pkg: resp_t enum (OKAY=2'b00, SLVERR=2'b10), write/read FSM state enums, and the address-decode function returning {in_range, index}.
- One natural sub-module, axi4l_addr_decode: a combinational range and index check, instanced once per channel.
- Both FSMs live in the top module.

Test Plan:
- AW+W same cycle at 0x0000_0010, WDATA 0x00E0_0000, BREADY=1 -> REG_WEN in t+1 with REG_WIDX=4 and REG_WDATA=0x00E00000; BVALID in t+1 with BRESP=00; AWREADY back high in t+2.
- W three cycles before AW, addr 0x8, data 0x0020_0000 -> WREADY low after the W beat; a single REG_WEN with REG_WIDX=2 after AW arrives; exactly one B beat.
- AR at 0x4 with regpool returning 0x1234_5678 and RREADY held low for 5 cycles -> REG_REN in t+1; RVALID in t+2 with stable RDATA=0x12345678, RRESP=00 until the RREADY edge; ARREADY low throughout.
- Write to 0x0000_1001 (misaligned) and read from 0x0001_0000 with AXI4L_SLVERR_EN defined -> no REG_WEN/REG_REN; BRESP=10; RRESP=10 with RDATA=0. Rerun undefined -> both responses 00.
- Concurrent write idx 7 and read idx 3 on the same edge -> REG_WEN and REG_REN in the same cycle; both responses complete independently.
- RSTN asserted in W_RESP with BVALID=1 -> BVALID=0 immediately (asynchronous). After release, all READYs are 1 and no spurious REG_WEN occurs.

Source files
------------

// File: rtl/axi4l_pkg.sv
// Shared types and the address-decode helper for the AXI4-Lite register responder.
package axi4l_pkg;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_t;

  typedef enum logic [2:0] {
    W_IDLE    = 3'd0,
    W_WAIT_W  = 3'd1,
    W_WAIT_AW = 3'd2,
    W_ISSUE   = 3'd3,
    W_RESP    = 3'd4
  } wstate_t;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_ISSUE = 2'd1,
    R_DATA  = 2'd2
  } rstate_t;

  localparam int DEC_ADDR_W = 64;
  localparam int DEC_IDX_W  = 32;

  typedef struct packed {
    logic                 in_range;
    logic [DEC_IDX_W-1:0] idx;
  } dec_t;

  // Word index is addr[idx_w+1:2]; in range only if word aligned and nothing set above the window.
  function automatic dec_t addr_decode(input logic [DEC_ADDR_W-1:0] addr, input int idx_w);
    dec_t                  d;
    logic [DEC_ADDR_W-1:0] upper;
    upper      = addr >> (idx_w + 2);
    d.in_range = (addr[1:0] == 2'b00) && (upper == {DEC_ADDR_W{1'b0}});
    d.idx      = addr[DEC_IDX_W+1:2] & ((DEC_IDX_W'(1) << idx_w) - DEC_IDX_W'(1));
    return d;
  endfunction

endpackage

// File: rtl/axi4l_addr_decode.sv
// Combinational range/alignment check and word-index extraction for one AXI channel.
module axi4l_addr_decode
  import axi4l_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int REG_IDX_WIDTH = 10
) (
  input  logic [ADDR_WIDTH-1:0]    addr,
  output logic                     in_range,
  output logic [REG_IDX_WIDTH-1:0] idx
);

  dec_t dec_s;
  logic unused_s;

  // Widen to the helper's fixed width and decode.
  always_comb begin
    dec_s = addr_decode(DEC_ADDR_W'(addr), REG_IDX_WIDTH);
  end

  assign in_range = dec_s.in_range;
  assign idx      = dec_s.idx[REG_IDX_WIDTH-1:0];
  // Bits above the index are always zero after masking.
  assign unused_s = ^dec_s.idx[DEC_IDX_W-1:REG_IDX_WIDTH];

endmodule

// File: rtl/axi4l_responder.sv
// AXI4-Lite slave turning AW/W/B and AR/R handshakes into single-cycle regpool strobes.
// Build option AXI4L_SLVERR_EN: out-of-range/misaligned accesses answer SLVERR instead of OKAY.
module axi4l_responder
  import axi4l_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int REG_IDX_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [ADDR_WIDTH-1:0]    awaddr,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [DATA_WIDTH/8-1:0]  wstrb,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [ADDR_WIDTH-1:0]    araddr,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [DATA_WIDTH-1:0]    rdata,
  output logic [1:0]               rresp,
  output logic                     rvalid,
  input  logic                     rready,
  output logic                     reg_wen,
  output logic [REG_IDX_WIDTH-1:0] reg_widx,
  output logic [DATA_WIDTH-1:0]    reg_wdata,
  output logic [DATA_WIDTH/8-1:0]  reg_wstrb,
  output logic                     reg_ren,
  output logic [REG_IDX_WIDTH-1:0] reg_ridx,
  input  logic [DATA_WIDTH-1:0]    reg_rdata
);

`ifdef AXI4L_SLVERR_EN
  localparam resp_t ERR_RESP = RESP_SLVERR;
`else
  localparam resp_t ERR_RESP = RESP_OKAY;
`endif

  wstate_t                  w_state_r, w_state_nxt_s;
  logic                     awready_r, awready_nxt_s;
  logic                     wready_r, wready_nxt_s;
  logic                     bvalid_r, bvalid_nxt_s;
  resp_t                    bresp_r, bresp_nxt_s;
  logic                     reg_wen_r, reg_wen_nxt_s;
  logic [REG_IDX_WIDTH-1:0] reg_widx_r, reg_widx_nxt_s;
  logic [DATA_WIDTH-1:0]    reg_wdata_r, reg_wdata_nxt_s;
  logic [DATA_WIDTH/8-1:0]  reg_wstrb_r, reg_wstrb_nxt_s;
  logic [ADDR_WIDTH-1:0]    aw_addr_r, aw_addr_nxt_s;
  logic [DATA_WIDTH-1:0]    w_data_r, w_data_nxt_s;
  logic [DATA_WIDTH/8-1:0]  w_strb_r, w_strb_nxt_s;
  logic [ADDR_WIDTH-1:0]    wr_addr_s;
  logic [DATA_WIDTH-1:0]    wr_data_s;
  logic [DATA_WIDTH/8-1:0]  wr_strb_s;
  logic                     wr_in_range_s;
  logic [REG_IDX_WIDTH-1:0] wr_idx_s;
  logic                     wr_issue_s;

  rstate_t                  r_state_r, r_state_nxt_s;
  logic                     arready_r, arready_nxt_s;
  logic                     rvalid_r, rvalid_nxt_s;
  resp_t                    rresp_r, rresp_nxt_s;
  logic                     reg_ren_r, reg_ren_nxt_s;
  logic [REG_IDX_WIDTH-1:0] reg_ridx_r, reg_ridx_nxt_s;
  logic                     r_ok_r, r_ok_nxt_s;
  logic                     r_first_r, r_first_nxt_s;
  logic [DATA_WIDTH-1:0]    rdata_r, rdata_nxt_s;
  logic [DATA_WIDTH-1:0]    rd_mux_s;
  logic                     rd_in_range_s;
  logic [REG_IDX_WIDTH-1:0] rd_idx_s;

  // A beat captured earlier is used in place of the live bus signal.
  assign wr_addr_s = (w_state_r == W_WAIT_W)  ? aw_addr_r : awaddr;
  assign wr_data_s = (w_state_r == W_WAIT_AW) ? w_data_r  : wdata;
  assign wr_strb_s = (w_state_r == W_WAIT_AW) ? w_strb_r  : wstrb;

  axi4l_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .REG_IDX_WIDTH(REG_IDX_WIDTH)) u_wr_dec (
    .addr     (wr_addr_s),
    .in_range (wr_in_range_s),
    .idx      (wr_idx_s)
  );

  axi4l_addr_decode #(.ADDR_WIDTH(ADDR_WIDTH), .REG_IDX_WIDTH(REG_IDX_WIDTH)) u_rd_dec (
    .addr     (araddr),
    .in_range (rd_in_range_s),
    .idx      (rd_idx_s)
  );

  // Write FSM next-state and next values of the registered write-side outputs.
  always_comb begin
    w_state_nxt_s   = w_state_r;
    awready_nxt_s   = 1'b0;
    wready_nxt_s    = 1'b0;
    bvalid_nxt_s    = bvalid_r;
    bresp_nxt_s     = bresp_r;
    reg_wen_nxt_s   = 1'b0;
    reg_widx_nxt_s  = reg_widx_r;
    reg_wdata_nxt_s = reg_wdata_r;
    reg_wstrb_nxt_s = reg_wstrb_r;
    aw_addr_nxt_s   = aw_addr_r;
    w_data_nxt_s    = w_data_r;
    w_strb_nxt_s    = w_strb_r;
    wr_issue_s      = 1'b0;
    case (w_state_r)
      W_IDLE: begin
        if (awvalid && awready_r && wvalid && wready_r) begin
          wr_issue_s = 1'b1;
        end else if (awvalid && awready_r) begin
          aw_addr_nxt_s = awaddr;
          w_state_nxt_s = W_WAIT_W;
          wready_nxt_s  = 1'b1;
        end else if (wvalid && wready_r) begin
          w_data_nxt_s  = wdata;
          w_strb_nxt_s  = wstrb;
          w_state_nxt_s = W_WAIT_AW;
          awready_nxt_s = 1'b1;
        end else begin
          awready_nxt_s = 1'b1;
          wready_nxt_s  = 1'b1;
        end
      end
      W_WAIT_W: begin
        if (wvalid && wready_r) begin
          wr_issue_s = 1'b1;
        end else begin
          wready_nxt_s = 1'b1;
        end
      end
      W_WAIT_AW: begin
        if (awvalid && awready_r) begin
          wr_issue_s = 1'b1;
        end else begin
          awready_nxt_s = 1'b1;
        end
      end
      W_ISSUE, W_RESP: begin
        if (bready) begin
          bvalid_nxt_s  = 1'b0;
          w_state_nxt_s = W_IDLE;
          awready_nxt_s = 1'b1;
          wready_nxt_s  = 1'b1;
        end else begin
          w_state_nxt_s = W_RESP;
        end
      end
      default: begin
        w_state_nxt_s = W_IDLE;
      end
    endcase
    if (wr_issue_s) begin
      w_state_nxt_s   = W_ISSUE;
      bvalid_nxt_s    = 1'b1;
      bresp_nxt_s     = wr_in_range_s ? RESP_OKAY : ERR_RESP;
      reg_wen_nxt_s   = wr_in_range_s;
      reg_widx_nxt_s  = wr_idx_s;
      reg_wdata_nxt_s = wr_data_s;
      reg_wstrb_nxt_s = wr_strb_s;
    end else begin
      reg_wen_nxt_s = 1'b0;
    end
  end

  // Write-side state and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_state_r   <= W_IDLE;
      awready_r   <= 1'b0;
      wready_r    <= 1'b0;
      bvalid_r    <= 1'b0;
      bresp_r     <= RESP_OKAY;
      reg_wen_r   <= 1'b0;
      reg_widx_r  <= {REG_IDX_WIDTH{1'b0}};
      reg_wdata_r <= {DATA_WIDTH{1'b0}};
      reg_wstrb_r <= {(DATA_WIDTH/8){1'b0}};
      aw_addr_r   <= {ADDR_WIDTH{1'b0}};
      w_data_r    <= {DATA_WIDTH{1'b0}};
      w_strb_r    <= {(DATA_WIDTH/8){1'b0}};
    end else begin
      w_state_r   <= w_state_nxt_s;
      awready_r   <= awready_nxt_s;
      wready_r    <= wready_nxt_s;
      bvalid_r    <= bvalid_nxt_s;
      bresp_r     <= bresp_nxt_s;
      reg_wen_r   <= reg_wen_nxt_s;
      reg_widx_r  <= reg_widx_nxt_s;
      reg_wdata_r <= reg_wdata_nxt_s;
      reg_wstrb_r <= reg_wstrb_nxt_s;
      aw_addr_r   <= aw_addr_nxt_s;
      w_data_r    <= w_data_nxt_s;
      w_strb_r    <= w_strb_nxt_s;
    end
  end

  assign rd_mux_s = r_ok_r ? reg_rdata : {DATA_WIDTH{1'b0}};

  // Read FSM next-state and next values of the registered read-side outputs.
  always_comb begin
    r_state_nxt_s  = r_state_r;
    arready_nxt_s  = 1'b0;
    rvalid_nxt_s   = rvalid_r;
    rresp_nxt_s    = rresp_r;
    reg_ren_nxt_s  = 1'b0;
    reg_ridx_nxt_s = reg_ridx_r;
    r_ok_nxt_s     = r_ok_r;
    r_first_nxt_s  = 1'b0;
    rdata_nxt_s    = rdata_r;
    case (r_state_r)
      R_IDLE: begin
        if (arvalid && arready_r) begin
          r_state_nxt_s  = R_ISSUE;
          reg_ren_nxt_s  = rd_in_range_s;
          reg_ridx_nxt_s = rd_idx_s;
          r_ok_nxt_s     = rd_in_range_s;
          rresp_nxt_s    = rd_in_range_s ? RESP_OKAY : ERR_RESP;
        end else begin
          arready_nxt_s = 1'b1;
        end
      end
      R_ISSUE: begin
        r_state_nxt_s = R_DATA;
        rvalid_nxt_s  = 1'b1;
        r_first_nxt_s = 1'b1;
      end
      R_DATA: begin
        if (r_first_r) begin
          rdata_nxt_s = rd_mux_s;
        end else begin
          rdata_nxt_s = rdata_r;
        end
        if (rready) begin
          rvalid_nxt_s  = 1'b0;
          r_state_nxt_s = R_IDLE;
          arready_nxt_s = 1'b1;
        end else begin
          r_state_nxt_s = R_DATA;
        end
      end
      default: begin
        r_state_nxt_s = R_IDLE;
      end
    endcase
  end

  // Read-side state and output registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state_r  <= R_IDLE;
      arready_r  <= 1'b0;
      rvalid_r   <= 1'b0;
      rresp_r    <= RESP_OKAY;
      reg_ren_r  <= 1'b0;
      reg_ridx_r <= {REG_IDX_WIDTH{1'b0}};
      r_ok_r     <= 1'b0;
      r_first_r  <= 1'b0;
      rdata_r    <= {DATA_WIDTH{1'b0}};
    end else begin
      r_state_r  <= r_state_nxt_s;
      arready_r  <= arready_nxt_s;
      rvalid_r   <= rvalid_nxt_s;
      rresp_r    <= rresp_nxt_s;
      reg_ren_r  <= reg_ren_nxt_s;
      reg_ridx_r <= reg_ridx_nxt_s;
      r_ok_r     <= r_ok_nxt_s;
      r_first_r  <= r_first_nxt_s;
      rdata_r    <= rdata_nxt_s;
    end
  end

  // Regpool data is only valid in the first R_DATA cycle, so it is passed through then and held after.
  assign rdata     = r_first_r ? rd_mux_s : rdata_r;
  assign rresp     = rresp_r;
  assign rvalid    = rvalid_r;
  assign arready   = arready_r;
  assign reg_ren   = reg_ren_r;
  assign reg_ridx  = reg_ridx_r;
  assign awready   = awready_r;
  assign wready    = wready_r;
  assign bvalid    = bvalid_r;
  assign bresp     = bresp_r;
  assign reg_wen   = reg_wen_r;
  assign reg_widx  = reg_widx_r;
  assign reg_wdata = reg_wdata_r;
  assign reg_wstrb = reg_wstrb_r;

endmodule

// File: tb/tb_axi4l_responder.sv
// Directed bench for axi4l_responder: vector table plus hand-written multi-cycle sequences.
module tb_axi4l_responder;

`ifdef AXI4L_SLVERR_EN
  localparam logic [1:0] ERR = 2'b10;
`else
  localparam logic [1:0] ERR = 2'b00;
`endif

  logic        clk;
  logic        rstn;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;
  logic        reg_wen;
  logic [9:0]  reg_widx;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_wstrb;
  logic        reg_ren;
  logic [9:0]  reg_ridx;
  logic [31:0] reg_rdata;

  int checks = 0;
  int errors = 0;
  int wen_cnt = 0;
  int b_cnt = 0;
  logic [31:0] pool [1024];

  axi4l_responder dut (
    .clk(clk), .rstn(rstn),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .reg_wen(reg_wen), .reg_widx(reg_widx), .reg_wdata(reg_wdata), .reg_wstrb(reg_wstrb),
    .reg_ren(reg_ren), .reg_ridx(reg_ridx), .reg_rdata(reg_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] strb_mask(input logic [3:0] s);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{s[b]}};
    return m;
  endfunction

  // Synchronous regpool model: read data appears the cycle after reg_ren, garbage otherwise.
  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 1024; i++)
        pool[i] <= (i == 1) ? 32'h1234_5678 : {16'hA500, 6'h00, 10'(i)};
      reg_rdata <= 32'hDEAD_BEEF;
    end else begin
      if (reg_wen)
        pool[reg_widx] <= (pool[reg_widx] & ~strb_mask(reg_wstrb)) | (reg_wdata & strb_mask(reg_wstrb));
      reg_rdata <= reg_ren ? pool[reg_ridx] : 32'hDEAD_BEEF;
    end
  end

  always @(posedge clk) begin
    if (reg_wen) wen_cnt <= wen_cnt + 1;
    if (bvalid && bready) b_cnt <= b_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (!(awready && wready && arready) && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("idle_ready", 32'(awready && wready && arready), 32'd1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          output logic stb, output logic [9:0] idx, output logic [31:0] wd,
                          output logic bv, output logic [1:0] br, output logic awb);
    wait_idle();
    awaddr = a; wdata = d; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    stb = reg_wen; idx = reg_widx; wd = reg_wdata; bv = bvalid; br = bresp;
    @(negedge clk);
    awb = awready;
  endtask

  task automatic do_read(input logic [31:0] a,
                         output logic stb, output logic [9:0] idx, output logic arl,
                         output logic rv, output logic [31:0] rd, output logic [1:0] rr);
    wait_idle();
    araddr = a; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    stb = reg_ren; idx = reg_ridx; arl = arready;
    @(negedge clk);
    rv = rvalid; rd = rdata; rr = rresp;
    @(negedge clk);
  endtask

  typedef struct {
    logic        is_rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic        exp_stb;
    logic [9:0]  exp_idx;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs [13];

  initial begin
    logic        stb, bv, rv, awb, arl;
    logic [9:0]  idx;
    logic [31:0] wd, rd;
    logic [1:0]  rsp;
    int          w0, b0;

    vecs[0]  = '{1'b0, 32'h0000_0010, 32'h00E0_0000, 1'b1, 10'd4,    2'b00, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b1, 10'd1023, 2'b00, 32'h0};
    vecs[2]  = '{1'b0, 32'h0000_1000, 32'h1111_1111, 1'b0, 10'd0,    ERR,   32'h0};
    vecs[3]  = '{1'b0, 32'h0000_1001, 32'h2222_2222, 1'b0, 10'd0,    ERR,   32'h0};
    vecs[4]  = '{1'b0, 32'h0000_0002, 32'h3333_3333, 1'b0, 10'd0,    ERR,   32'h0};
    vecs[5]  = '{1'b1, 32'h0000_0004, 32'h0,         1'b1, 10'd1,    2'b00, 32'h1234_5678};
    vecs[6]  = '{1'b1, 32'h0000_0010, 32'h0,         1'b1, 10'd4,    2'b00, 32'h00E0_0000};
    vecs[7]  = '{1'b1, 32'h0000_0FFC, 32'h0,         1'b1, 10'd1023, 2'b00, 32'hCAFE_F00D};
    vecs[8]  = '{1'b1, 32'h0001_0000, 32'h0,         1'b0, 10'd0,    ERR,   32'h0};
    vecs[9]  = '{1'b1, 32'h0000_0003, 32'h0,         1'b0, 10'd0,    ERR,   32'h0};
    vecs[10] = '{1'b1, 32'h8000_0000, 32'h0,         1'b0, 10'd0,    ERR,   32'h0};
    vecs[11] = '{1'b1, 32'h0000_0000, 32'h0,         1'b1, 10'd0,    2'b00, 32'hA500_0000};
    vecs[12] = '{1'b1, 32'h0000_0008, 32'h0,         1'b1, 10'd2,    2'b00, 32'hA500_0002};

    rstn = 1'b0; awaddr = 32'h0; awvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0;
    bready = 1'b0; araddr = 32'h0; arvalid = 1'b0; rready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_strobes", 32'({reg_wen, reg_ren}), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_resp", 32'({bresp, rresp}), 32'd0);
    chk("rst_widx", 32'(reg_widx), 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    chk("rel_readies", 32'({awready, wready, arready}), 32'd7);
    bready = 1'b1; rready = 1'b1;

    for (int i = 0; i < 13; i++) begin
      if (!vecs[i].is_rd) begin
        do_write(vecs[i].addr, vecs[i].data, stb, idx, wd, bv, rsp, awb);
        chk($sformatf("v%0d_wen", i), 32'(stb), 32'(vecs[i].exp_stb));
        chk($sformatf("v%0d_bvalid", i), 32'(bv), 32'd1);
        chk($sformatf("v%0d_bresp", i), 32'(rsp), 32'(vecs[i].exp_resp));
        chk($sformatf("v%0d_awready_t2", i), 32'(awb), 32'd1);
        if (vecs[i].exp_stb) begin
          chk($sformatf("v%0d_widx", i), 32'(idx), 32'(vecs[i].exp_idx));
          chk($sformatf("v%0d_wdata", i), wd, vecs[i].data);
        end
      end else begin
        do_read(vecs[i].addr, stb, idx, arl, rv, rd, rsp);
        chk($sformatf("v%0d_ren", i), 32'(stb), 32'(vecs[i].exp_stb));
        chk($sformatf("v%0d_arready_low", i), 32'(arl), 32'd0);
        chk($sformatf("v%0d_rvalid", i), 32'(rv), 32'd1);
        chk($sformatf("v%0d_rresp", i), 32'(rsp), 32'(vecs[i].exp_resp));
        chk($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
        if (vecs[i].exp_stb) chk($sformatf("v%0d_ridx", i), 32'(idx), 32'(vecs[i].exp_idx));
      end
    end

    // W three cycles before AW
    wait_idle();
    w0 = wen_cnt; b0 = b_cnt;
    wdata = 32'h0020_0000; wstrb = 4'hF; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    chk("wfirst_wready_low", 32'(wready), 32'd0);
    chk("wfirst_awready_high", 32'(awready), 32'd1);
    repeat (2) @(negedge clk);
    chk("wfirst_wready_held", 32'(wready), 32'd0);
    chk("wfirst_no_wen_yet", 32'(wen_cnt - w0), 32'd0);
    awaddr = 32'h0000_0008; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("wfirst_wen", 32'(reg_wen), 32'd1);
    chk("wfirst_widx", 32'(reg_widx), 32'd2);
    chk("wfirst_wdata", reg_wdata, 32'h0020_0000);
    chk("wfirst_bvalid", 32'(bvalid), 32'd1);
    repeat (3) @(negedge clk);
    chk("wfirst_one_wen", 32'(wen_cnt - w0), 32'd1);
    chk("wfirst_one_b", 32'(b_cnt - b0), 32'd1);

    // Read with RREADY held low for 5 cycles
    wait_idle();
    rready = 1'b0;
    araddr = 32'h0000_0004; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    chk("stall_ren", 32'(reg_ren), 32'd1);
    chk("stall_ridx", 32'(reg_ridx), 32'd1);
    chk("stall_rvalid_t1", 32'(rvalid), 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("stall_rvalid_c%0d", k), 32'(rvalid), 32'd1);
      chk($sformatf("stall_rdata_c%0d", k), rdata, 32'h1234_5678);
      chk($sformatf("stall_rresp_c%0d", k), 32'(rresp), 32'd0);
      chk($sformatf("stall_arready_c%0d", k), 32'(arready), 32'd0);
    end
    rready = 1'b1;
    @(negedge clk);
    chk("stall_rvalid_done", 32'(rvalid), 32'd0);
    chk("stall_arready_back", 32'(arready), 32'd1);

    // Concurrent write idx 7 and read idx 3
    wait_idle();
    awaddr = 32'h0000_001C; wdata = 32'h0000_0777; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h0000_000C; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("conc_strobes", 32'({reg_wen, reg_ren}), 32'd3);
    chk("conc_widx", 32'(reg_widx), 32'd7);
    chk("conc_ridx", 32'(reg_ridx), 32'd3);
    chk("conc_bvalid", 32'(bvalid), 32'd1);
    @(negedge clk);
    chk("conc_rvalid", 32'(rvalid), 32'd1);
    chk("conc_rdata", rdata, 32'hA500_0003);
    chk("conc_bdone", 32'(bvalid), 32'd0);

    // Same index written and read on one edge returns the pre-write value
    wait_idle();
    awaddr = 32'h0000_0014; wdata = 32'h0000_0055; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h0000_0014; arvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("same_strobes", 32'({reg_wen, reg_ren}), 32'd3);
    @(negedge clk);
    chk("same_rdata_old", rdata, 32'hA500_0005);
    do_read(32'h0000_0014, stb, idx, arl, rv, rd, rsp);
    chk("same_rdata_new", rd, 32'h0000_0055);

    // Reset while BVALID is stalled, then a half-captured write across reset
    wait_idle();
    bready = 1'b0;
    awaddr = 32'h0000_0020; wdata = 32'h0000_00AA; awvalid = 1'b1; wvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("rstmid_bvalid_t1", 32'(bvalid), 32'd1);
    @(negedge clk);
    chk("rstmid_bvalid_held", 32'(bvalid), 32'd1);
    w0 = wen_cnt;
    #2 rstn = 1'b0;
    #1;
    chk("rstmid_bvalid_cleared", 32'(bvalid), 32'd0);
    chk("rstmid_strobes", 32'({reg_wen, reg_ren}), 32'd0);
    chk("rstmid_awready", 32'(awready), 32'd0);
    @(negedge clk);
    rstn = 1'b1; bready = 1'b1;
    @(negedge clk);
    chk("rstmid_readies", 32'({awready, wready, arready}), 32'd7);
    wdata = 32'h0000_00BB; wvalid = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    chk("half_wready_low", 32'(wready), 32'd0);
    #2 rstn = 1'b0;
    #1;
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    chk("half_no_wen", 32'(wen_cnt - w0), 32'd0);
    chk("half_readies", 32'({awready, wready, arready}), 32'd7);
    chk("half_bvalid", 32'(bvalid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
